matrix_slot_allocator: RTL and testbench

MATRIX_SLOT_ALLOCATOR -- requirements
Module: matrix_slot_allocator

---
 rtl/matrix_slot_allocator_pkg.sv | 29 ++
 rtl/matrix_slot_allocator_if.sv | 33 +++
 rtl/slot_scan_unit.sv | 76 +++++++
 rtl/matrix_slot_allocator.sv | 174 +++++++++++++++++
 tb/tb_matrix_slot_allocator.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_slot_allocator_pkg.sv
// Shared constants, FSM state encoding and slot descriptor record for the
// matrix slot allocator.
package matrix_slot_allocator_pkg;

  localparam int unsigned NUM_SLOTS   = 16;
  localparam int unsigned SLOT_WORDS  = 25;
  localparam int unsigned MAX_PER_DIM = 2;
  localparam int unsigned MAX_DIM     = 5;
  localparam int unsigned AGE_MAX     = 15;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StGrant,
    StFill
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] m;
    logic [2:0] n;
    logic [3:0] age;
  } slot_desc_t;

  function automatic logic dim_ok(input logic [31:0] d);
    return (d >= 32'd1) && (d <= 32'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matrix_slot_allocator_if.sv
// Request/commit/query signal bundle between the input subsystem and the allocator.
interface matrix_slot_allocator_if;

  logic        en;
  logic        alloc_req;
  logic [31:0] req_m;
  logic [31:0] req_n;
  logic        fill_done;
  logic [3:0]  qry_id;
  logic [8:0]  base_addr;
  logic        addr_ready;
  logic        alloc_err;
  logic        commit_pulse;
  logic [3:0]  commit_id;
  logic        busy;
  logic        qry_valid;
  logic [2:0]  qry_m;
  logic [2:0]  qry_n;
  logic [8:0]  qry_base;

  modport slave (
    input  en, alloc_req, req_m, req_n, fill_done, qry_id,
    output base_addr, addr_ready, alloc_err, commit_pulse, commit_id, busy,
    output qry_valid, qry_m, qry_n, qry_base
  );

  modport master (
    output en, alloc_req, req_m, req_n, fill_done, qry_id,
    input  base_addr, addr_ready, alloc_err, commit_pulse, commit_id, busy,
    input  qry_valid, qry_m, qry_n, qry_base
  );

endinterface

// File: rtl/slot_scan_unit.sv
// Per-cycle slot comparison during SCAN; keeps the best free / same-dims /
// oldest candidates and resolves the victim from them.
module slot_scan_unit #(
  parameter int unsigned NUM_SLOTS   = matrix_slot_allocator_pkg::NUM_SLOTS,
  parameter int unsigned MAX_PER_DIM = matrix_slot_allocator_pkg::MAX_PER_DIM
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_clear,
  input  logic                                 i_visit,
  input  logic [3:0]                           i_idx,
  input  matrix_slot_allocator_pkg::slot_desc_t i_desc,
  input  logic [2:0]                           i_m,
  input  logic [2:0]                           i_n,
  output logic [3:0]                           o_victim
);
  import matrix_slot_allocator_pkg::*;

  localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

  logic             r_free_found;
  logic [3:0]       r_free_idx;
  logic [CNT_W-1:0] r_same_cnt;
  logic             r_same_found;
  logic [3:0]       r_same_idx;
  logic [3:0]       r_same_age;
  logic             r_old_found;
  logic [3:0]       r_old_idx;
  logic [3:0]       r_old_age;
  logic             w_same;

  assign w_same = i_desc.valid && (i_desc.m == i_m) && (i_desc.n == i_n);

  // Strict '>' keeps the lowest index on age ties since indices rise monotonically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || i_clear) begin
      r_free_found <= 1'b0;
      r_free_idx   <= '0;
      r_same_cnt   <= '0;
      r_same_found <= 1'b0;
      r_same_idx   <= '0;
      r_same_age   <= '0;
      r_old_found  <= 1'b0;
      r_old_idx    <= '0;
      r_old_age    <= '0;
    end else if (i_visit) begin
      if (!i_desc.valid && !r_free_found) begin
        r_free_found <= 1'b1;
        r_free_idx   <= i_idx;
      end
      if (w_same) begin
        r_same_cnt <= r_same_cnt + CNT_W'(1);
        if (!r_same_found || (i_desc.age > r_same_age)) begin
          r_same_found <= 1'b1;
          r_same_idx   <= i_idx;
          r_same_age   <= i_desc.age;
        end
      end
      if (i_desc.valid && (!r_old_found || (i_desc.age > r_old_age))) begin
        r_old_found <= 1'b1;
        r_old_idx   <= i_idx;
        r_old_age   <= i_desc.age;
      end
    end
  end

  always_comb begin
    o_victim = r_old_idx;
    if (r_same_cnt >= CNT_W'(MAX_PER_DIM)) begin
      o_victim = r_same_idx;
    end else if (r_free_found) begin
      o_victim = r_free_idx;
    end
  end

endmodule

// File: rtl/matrix_slot_allocator.sv
// Matrix memory slot allocator: descriptor table, control FSM and registered
// slot query port.
module matrix_slot_allocator #(
  parameter int unsigned NUM_SLOTS   = matrix_slot_allocator_pkg::NUM_SLOTS,
  parameter int unsigned SLOT_WORDS  = matrix_slot_allocator_pkg::SLOT_WORDS,
  parameter int unsigned MAX_PER_DIM = matrix_slot_allocator_pkg::MAX_PER_DIM
) (
  input logic                    clk,
  input logic                    rst_n,
  matrix_slot_allocator_if.slave bus
);
  import matrix_slot_allocator_pkg::*;

  state_e      r_state, w_state_d;
  slot_desc_t  r_table [NUM_SLOTS];
  logic [31:0] r_req_m, r_req_n;
  logic [3:0]  r_scan_idx;
  logic [3:0]  r_victim;
  logic [3:0]  w_victim;
  logic        w_clear, w_visit, w_grant, w_commit, w_err, w_dims_ok;

  logic [8:0]  r_base_addr;
  logic        r_addr_ready, r_alloc_err, r_commit_pulse;
  logic [3:0]  r_commit_id;
  logic        r_qry_valid;
  logic [2:0]  r_qry_m, r_qry_n;
  logic [8:0]  r_qry_base;

  function automatic logic [8:0] slot_base(input logic [3:0] idx);
    return 9'(32'(idx) * SLOT_WORDS);
  endfunction

  assign w_dims_ok = dim_ok(r_req_m) && dim_ok(r_req_n);

  always_comb begin
    w_state_d = r_state;
    w_clear   = 1'b0;
    w_visit   = 1'b0;
    w_grant   = 1'b0;
    w_commit  = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.en && bus.alloc_req) begin
          w_state_d = StScan;
          w_clear   = 1'b1;
        end
      end
      StScan: begin
        if (!bus.en) begin
          w_state_d = StIdle;
        end else if (!w_dims_ok) begin
          w_state_d = StIdle;
          w_err     = 1'b1;
        end else begin
          w_visit = 1'b1;
          if (r_scan_idx == 4'(NUM_SLOTS - 1)) w_state_d = StGrant;
        end
      end
      StGrant: begin
        w_state_d = StIdle;
        if (bus.en) begin
          w_state_d = StFill;
          w_grant   = 1'b1;
        end
      end
      StFill: begin
        if (!bus.en) begin
          w_state_d = StIdle;
        end else if (bus.fill_done) begin
          w_state_d = StIdle;
          w_commit  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_req_m    <= '0;
      r_req_n    <= '0;
      r_scan_idx <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_clear) begin
        r_req_m    <= bus.req_m;
        r_req_n    <= bus.req_n;
        r_scan_idx <= '0;
      end else if (w_visit) begin
        r_scan_idx <= r_scan_idx + 4'd1;
      end
    end
  end

  slot_scan_unit #(
    .NUM_SLOTS   (NUM_SLOTS),
    .MAX_PER_DIM (MAX_PER_DIM)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_visit  (w_visit),
    .i_idx    (r_scan_idx),
    .i_desc   (r_table[r_scan_idx]),
    .i_m      (r_req_m[2:0]),
    .i_n      (r_req_n[2:0]),
    .o_victim (w_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_ready   <= 1'b0;
      r_alloc_err    <= 1'b0;
      r_commit_pulse <= 1'b0;
      r_base_addr    <= '0;
      r_victim       <= '0;
      r_commit_id    <= '0;
    end else begin
      r_addr_ready   <= w_grant;
      r_alloc_err    <= w_err;
      r_commit_pulse <= w_commit;
      if (w_grant) begin
        r_base_addr <= slot_base(w_victim);
        r_victim    <= w_victim;
      end
      if (w_commit) r_commit_id <= r_victim;
    end
  end

  // The victim stays invalid from grant until commit, so an abort leaves it free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) r_table[i] <= '0;
    end else if (w_grant) begin
      r_table[w_victim].valid <= 1'b0;
    end else if (w_commit) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (4'(i) == r_victim) begin
          r_table[i] <= '{valid: 1'b1, m: r_req_m[2:0], n: r_req_n[2:0], age: 4'd0};
        end else if (r_table[i].valid && (r_table[i].age != 4'(AGE_MAX))) begin
          r_table[i].age <= r_table[i].age + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qry_valid <= 1'b0;
      r_qry_m     <= '0;
      r_qry_n     <= '0;
      r_qry_base  <= '0;
    end else begin
      r_qry_valid <= r_table[bus.qry_id].valid;
      r_qry_m     <= r_table[bus.qry_id].m;
      r_qry_n     <= r_table[bus.qry_id].n;
      r_qry_base  <= slot_base(bus.qry_id);
    end
  end

  assign bus.base_addr    = r_base_addr;
  assign bus.addr_ready   = r_addr_ready;
  assign bus.alloc_err    = r_alloc_err;
  assign bus.commit_pulse = r_commit_pulse;
  assign bus.commit_id    = r_commit_id;
  assign bus.busy         = (r_state != StIdle);
  assign bus.qry_valid    = r_qry_valid;
  assign bus.qry_m        = r_qry_m;
  assign bus.qry_n        = r_qry_n;
  assign bus.qry_base     = r_qry_base;

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Self-checking bench for matrix_slot_allocator: directed vector table, corner
// sequences and random requests checked against a slot-table model.
module tb_matrix_slot_allocator;

  logic clk = 1'b0;
  logic rst_n;

  matrix_slot_allocator_if bus ();

  matrix_slot_allocator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference slot table
  bit m_valid [16];
  int m_m     [16];
  int m_n     [16];
  int m_age   [16];

  typedef struct {
    int m;
    int n;
    bit err;
    int victim;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_m[i]     = 0;
      m_n[i]     = 0;
      m_age[i]   = 0;
    end
  endfunction

  function automatic int predict(input int m, input int n);
    int same_cnt = 0;
    int same_idx = -1;
    int free_idx = -1;
    int old_idx  = -1;
    for (int i = 0; i < 16; i++) begin
      if (!m_valid[i]) begin
        if (free_idx < 0) free_idx = i;
      end else begin
        if (m_m[i] == m && m_n[i] == n) begin
          same_cnt++;
          if (same_idx < 0 || m_age[i] > m_age[same_idx]) same_idx = i;
        end
        if (old_idx < 0 || m_age[i] > m_age[old_idx]) old_idx = i;
      end
    end
    if (same_cnt >= 2) return same_idx;
    if (free_idx >= 0) return free_idx;
    return old_idx;
  endfunction

  function automatic void model_commit(input int v, input int m, input int n);
    for (int i = 0; i < 16; i++) begin
      if (i != v && m_valid[i] && m_age[i] < 15) m_age[i]++;
    end
    m_valid[v] = 1'b1;
    m_m[v]     = m;
    m_n[v]     = n;
    m_age[v]   = 0;
  endfunction

  task automatic apply_reset();
    bus.en        = 1'b0;
    bus.alloc_req = 1'b0;
    bus.fill_done = 1'b0;
    bus.req_m     = '0;
    bus.req_n     = '0;
    bus.qry_id    = '0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b1;
    model_reset();
  endtask

  // Issues one request; leaves the DUT in FILL after a grant, or IDLE after an error.
  task automatic do_alloc(input int m, input int n, input bit exp_err, input int exp_v,
                          input string tag);
    int cyc_ready = 0;
    int n_ready   = 0;
    int n_err     = 0;
    bus.req_m     = m;
    bus.req_n     = n;
    bus.en        = 1'b1;
    bus.alloc_req = 1'b1;
    @(posedge clk);
    #1;
    bus.alloc_req = 1'b0;
    if (exp_err) begin
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk);
        #1;
        if (bus.alloc_err) n_err++;
        if (bus.addr_ready) n_ready++;
      end
      check({tag, " err_pulses"}, n_err, 1);
      check({tag, " err_no_grant"}, n_ready, 0);
      check({tag, " err_busy"}, bus.busy, 0);
    end else begin
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk);
        #1;
        if (c == 1) check({tag, " busy"}, bus.busy, 1);
        if (bus.alloc_err) n_err++;
        if (bus.addr_ready) begin
          cyc_ready = c;
          break;
        end
      end
      check({tag, " latency"}, cyc_ready, 17);
      check({tag, " no_err"}, n_err, 0);
      check({tag, " base_addr"}, bus.base_addr, exp_v * 25);
      m_valid[exp_v] = 1'b0;
      bus.qry_id = 4'(exp_v);
      @(posedge clk);
      #1;
      check({tag, " ready_pulse"}, bus.addr_ready, 0);
      check({tag, " base_hold"}, bus.base_addr, exp_v * 25);
      check({tag, " victim_invalid"}, bus.qry_valid, 0);
    end
  endtask

  task automatic do_fill(input int v, input int m, input int n, input string tag);
    bus.qry_id    = 4'(v);
    bus.fill_done = 1'b1;
    @(posedge clk);
    #1;
    bus.fill_done = 1'b0;
    check({tag, " commit_pulse"}, bus.commit_pulse, 1);
    check({tag, " commit_id"}, bus.commit_id, v);
    check({tag, " qry_precommit"}, bus.qry_valid, 0);
    model_commit(v, m, n);
    @(posedge clk);
    #1;
    check({tag, " commit_single"}, bus.commit_pulse, 0);
    check({tag, " idle"}, bus.busy, 0);
    check({tag, " qry_valid"}, bus.qry_valid, 1);
    check({tag, " qry_m"}, bus.qry_m, m);
    check({tag, " qry_n"}, bus.qry_n, n);
    check({tag, " qry_base"}, bus.qry_base, v * 25);
  endtask

  initial begin
    int n_bad;
    int rm, rn, rv, q;
    bit rbad;

    vecs[0] = '{3, 3, 1'b0, 0};
    vecs[1] = '{6, 2, 1'b1, 0};
    vecs[2] = '{2, 0, 1'b1, 0};
    vecs[3] = '{19, 1, 1'b1, 0};
    vecs[4] = '{2, 2, 1'b0, 1};
    vecs[5] = '{2, 2, 1'b0, 2};
    vecs[6] = '{2, 2, 1'b0, 1};
    vecs[7] = '{5, 5, 1'b0, 3};
    vecs[8] = '{2, 2, 1'b0, 2};
    vecs[9] = '{1, 5, 1'b0, 4};

    // Reset state
    bus.en        = 1'b0;
    bus.alloc_req = 1'b0;
    bus.fill_done = 1'b0;
    bus.req_m     = '0;
    bus.req_n     = '0;
    bus.qry_id    = '0;
    rst_n         = 1'b0;
    #1;
    check("rst busy", bus.busy, 0);
    check("rst addr_ready", bus.addr_ready, 0);
    check("rst base_addr", bus.base_addr, 0);
    check("rst commit_id", bus.commit_id, 0);
    check("rst qry_valid", bus.qry_valid, 0);
    apply_reset();

    // Directed vectors from a fresh table
    for (int i = 0; i < 10; i++) begin
      do_alloc(vecs[i].m, vecs[i].n, vecs[i].err, vecs[i].victim, $sformatf("vec%0d", i));
      if (!vecs[i].err) do_fill(vecs[i].victim, vecs[i].m, vecs[i].n, $sformatf("vec%0d", i));
    end

    // Fill every slot with distinct dims, then evict the oldest
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      do_alloc(1 + i % 5, 1 + i / 5, 1'b0, i, $sformatf("fill%0d", i));
      do_fill(i, 1 + i % 5, 1 + i / 5, $sformatf("fill%0d", i));
    end
    do_alloc(5, 5, 1'b0, 0, "evict_oldest");
    do_fill(0, 5, 5, "evict_oldest");

    // Same-dims eviction, ignored strobes, abort in FILL
    apply_reset();
    do_alloc(2, 2, 1'b0, 0, "dup_a");
    do_fill(0, 2, 2, "dup_a");
    do_alloc(2, 2, 1'b0, 1, "dup_b");
    do_fill(1, 2, 2, "dup_b");
    do_alloc(2, 2, 1'b0, 0, "dup_c");
    do_fill(0, 2, 2, "dup_c");
    bus.fill_done = 1'b1;
    @(posedge clk);
    #1;
    bus.fill_done = 1'b0;
    @(posedge clk);
    #1;
    check("idle_fill_done commit", bus.commit_pulse, 0);
    check("idle_fill_done busy", bus.busy, 0);
    do_alloc(3, 1, 1'b0, 2, "s2");
    do_fill(2, 3, 1, "s2");
    do_alloc(3, 2, 1'b0, 3, "s3");
    do_fill(3, 3, 2, "s3");
    do_alloc(4, 1, 1'b0, 4, "s4");
    bus.alloc_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fill_req busy", bus.busy, 1);
    check("fill_req no_grant", bus.addr_ready, 0);
    bus.alloc_req = 1'b0;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", bus.busy, 0);
    check("abort commit", bus.commit_pulse, 0);
    bus.en = 1'b1;
    bus.qry_id = 4'd4;
    @(posedge clk);
    #1;
    check("abort commit_late", bus.commit_pulse, 0);
    check("abort slot4 invalid", bus.qry_valid, 0);

    // Reset in the middle of SCAN
    bus.qry_id = 4'd1;
    @(posedge clk);
    #1;
    check("pre_rst qry_valid", bus.qry_valid, 1);
    bus.req_m     = 1;
    bus.req_n     = 1;
    bus.alloc_req = 1'b1;
    @(posedge clk);
    #1;
    bus.alloc_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("scan busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", bus.busy, 0);
    check("midrst addr_ready", bus.addr_ready, 0);
    check("midrst alloc_err", bus.alloc_err, 0);
    check("midrst commit_pulse", bus.commit_pulse, 0);
    check("midrst commit_id", bus.commit_id, 0);
    check("midrst base_addr", bus.base_addr, 0);
    check("midrst qry_valid", bus.qry_valid, 0);
    check("midrst qry_m", bus.qry_m, 0);
    check("midrst qry_n", bus.qry_n, 0);
    check("midrst qry_base", bus.qry_base, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (bus.addr_ready || bus.busy) n_bad++;
    end
    check("post_rst no_grant", n_bad, 0);
    check("post_rst slot1 cleared", bus.qry_valid, 0);
    model_reset();

    // Random requests against the reference table
    for (int it = 0; it < 40; it++) begin
      rm = $urandom_range(1, 3);
      rn = $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) rm = ($urandom_range(0, 1) == 0) ? 0 : 7;
      if ($urandom_range(0, 9) == 0) rn = 6;
      rbad = (rm < 1 || rm > 5 || rn < 1 || rn > 5);
      rv = rbad ? 0 : predict(rm, rn);
      do_alloc(rm, rn, rbad, rv, $sformatf("rand%0d", it));
      if (!rbad) begin
        if ($urandom_range(0, 7) == 0) begin
          bus.en = 1'b0;
          @(posedge clk);
          #1;
          check("rand abort busy", bus.busy, 0);
          check("rand abort commit", bus.commit_pulse, 0);
          bus.en = 1'b1;
        end else begin
          do_fill(rv, rm, rn, $sformatf("rand%0d", it));
        end
      end
      q = $urandom_range(0, 15);
      bus.qry_id = 4'(q);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d qry%0d valid", it, q), bus.qry_valid, m_valid[q]);
      check($sformatf("rand%0d qry%0d base", it, q), bus.qry_base, q * 25);
      if (m_valid[q]) begin
        check($sformatf("rand%0d qry%0d m", it, q), bus.qry_m, m_m[q]);
        check($sformatf("rand%0d qry%0d n", it, q), bus.qry_n, m_n[q]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
